// File: rtl/contador_param.sv
// Parametrised modulo-MOD up/down counter with parallel load, registered
// terminal-count pulse and sticky overflow flag. Define CONTADOR_SAT_EN to saturate instead of wrap.
module contador_param #(
    parameter int WIDTH = 9,
    parameter int MOD   = 512,
    parameter int INIT  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             add,
    input  logic             sub,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] s,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

    if (MOD < 2 || (WIDTH < 31 && MOD > (1 << WIDTH))) begin : g_bad_mod
        $error("contador_param: MOD=%0d outside 2..2**WIDTH", MOD);
    end
    if (INIT < 0 || INIT >= MOD) begin : g_bad_init
        $error("contador_param: INIT=%0d must be below MOD", INIT);
    end

    logic [WIDTH-1:0] s_q, s_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             up, down, boundary;

    // Both enables together cancel out; load always outranks counting.
    assign up   = add & ~sub & ~load;
    assign down = sub & ~add & ~load;

    always_comb begin
        s_d      = s_q;
        boundary = 1'b0;
        if (load) begin
            s_d = ({1'b0, load_val} < MOD_W) ? load_val : MAX_V;
        end else if (up) begin
            if (s_q == MAX_V) begin
                boundary = 1'b1;
`ifdef CONTADOR_SAT_EN
                s_d = MAX_V;
`else
                s_d = '0;
`endif
            end else begin
                s_d = s_q + 1'b1;
            end
        end else if (down) begin
            if (s_q == '0) begin
                boundary = 1'b1;
`ifdef CONTADOR_SAT_EN
                s_d = '0;
`else
                s_d = MAX_V;
`endif
            end else begin
                s_d = s_q - 1'b1;
            end
        end
        // A boundary event on the same edge as clr_ovf leaves the flag set.
        tc_d  = boundary;
        ovf_d = boundary | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q   <= INIT_V;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign s   = s_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule
